// File: rtl/db_ctrl_if.sv
// db_ctrl_if: job request (start_i, sao_en_i, ctu_x_i/ctu_y_i) and status (state_o, cnt_o, sys_ctu_*_o, busy_o, done_o) bundle for db_ctrl
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
`ifndef PIC_Y_WIDTH
`define PIC_Y_WIDTH 8
`endif
interface db_ctrl_if;
  logic                    start_i;
  logic                    sao_en_i;
  logic [`PIC_X_WIDTH-1:0] ctu_x_i;
  logic [`PIC_Y_WIDTH-1:0] ctu_y_i;
  logic [2:0]              state_o;
  logic [8:0]              cnt_o;
  logic [`PIC_X_WIDTH-1:0] sys_ctu_x_o;
  logic [`PIC_Y_WIDTH-1:0] sys_ctu_y_o;
  logic                    busy_o;
  logic                    done_o;
  modport master (
    output start_i, sao_en_i, ctu_x_i, ctu_y_i,
    input  state_o, cnt_o, sys_ctu_x_o, sys_ctu_y_o, busy_o, done_o
  );
  modport slave (
    input  start_i, sao_en_i, ctu_x_i, ctu_y_i,
    output state_o, cnt_o, sys_ctu_x_o, sys_ctu_y_o, busy_o, done_o
  );
endinterface

// File: rtl/db_ctrl.sv
// db_ctrl: per-CTU phase sequencer LOAD->DBY->DBU->DBV->[SAO]->OUT with phase counter, latched CTU position, busy and done pulse
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
`ifndef PIC_Y_WIDTH
`define PIC_Y_WIDTH 8
`endif
module db_ctrl #(
  parameter int LOAD_LEN = 65,
  parameter int DBY_LEN  = 260,
  parameter int DBC_LEN  = 132,
  parameter int SAO_LEN  = 256,
  parameter int OUT_LEN  = 384
) (
  input logic       clk,
  input logic       rst,
  db_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    DBY  = 3'b011,
    DBU  = 3'b010,
    DBV  = 3'b110,
    SAO  = 3'b100,
    OUT  = 3'b101
  } state_t;
  state_t                  state, nxt;
  logic [8:0]              cnt, last_m1;
  logic                    busy, done, sao_q;
  logic [`PIC_X_WIDTH-1:0] x_q;
  logic [`PIC_Y_WIDTH-1:0] y_q;
  always_comb begin
    last_m1 = state == LOAD ? 9'(LOAD_LEN - 1) :
              state == DBY  ? 9'(DBY_LEN - 1)  :
              (state == DBU || state == DBV) ? 9'(DBC_LEN - 1) :
              state == SAO  ? 9'(SAO_LEN - 1)  : 9'(OUT_LEN - 1);
    nxt = state == LOAD ? DBY :
          state == DBY  ? DBU :
          state == DBU  ? DBV :
          state == DBV  ? (sao_q ? SAO : OUT) :
          state == SAO  ? OUT : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sao_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start_i) begin
          state <= LOAD;
          busy  <= 1'b1;
          sao_q <= bus.sao_en_i;
          x_q   <= bus.ctu_x_i;
          y_q   <= bus.ctu_y_i;
        end
      end else if (cnt == last_m1) begin
        state <= nxt;
        cnt   <= '0;
        busy  <= nxt != IDLE;
        done  <= nxt == IDLE;
      end else begin
        cnt <= cnt + 9'd1;
      end
    end
  end
  assign bus.state_o     = state;
  assign bus.cnt_o       = cnt;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.sys_ctu_x_o = x_q;
  assign bus.sys_ctu_y_o = y_q;
endmodule

// File: tb/tb_db_ctrl.sv
// tb_db_ctrl: directed jobs against a phase-table job model, per-cycle compare plus literal latency/phase checks
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
`ifndef PIC_Y_WIDTH
`define PIC_Y_WIDTH 8
`endif
module tb_db_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  db_ctrl_if bus ();
  db_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam int PH_LEN [6] = '{65, 260, 132, 132, 256, 384};
  localparam logic [2:0] PH_CODE [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  function automatic int total(input bit sao);
    int t = 0;
    for (int i = 0; i < 6; i++) if (i != 4 || sao) t += PH_LEN[i];
    return t;
  endfunction
  function automatic void exp_at(input int k, input bit sao, output logic [2:0] s, output int c);
    bit found = 1'b0;
    s = 3'b000;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      if (!found && (i != 4 || sao)) begin
        if (k < PH_LEN[i]) begin
          s = PH_CODE[i];
          c = k;
          found = 1'b1;
        end else k -= PH_LEN[i];
      end
    end
  endfunction
  bit                      m_busy, m_done, m_sao;
  int                      m_k;
  logic [`PIC_X_WIDTH-1:0] m_x;
  logic [`PIC_Y_WIDTH-1:0] m_y;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_sao = 0; m_k = 0; m_x = '0; m_y = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (m_k == total(m_sao) - 1) begin
          m_busy = 0; m_done = 1; m_k = 0;
        end else m_k++;
      end else if (bus.start_i) begin
        m_busy = 1; m_k = 0; m_sao = bus.sao_en_i; m_x = bus.ctu_x_i; m_y = bus.ctu_y_i;
      end
    end
  end
  logic [2:0] e_s;
  int         e_c;
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_busy) exp_at(m_k, m_sao, e_s, e_c);
      else begin e_s = 3'b000; e_c = 0; end
      tests++;
      if (bus.state_o !== e_s || bus.cnt_o !== 9'(e_c) || bus.busy_o !== m_busy || bus.done_o !== m_done ||
          bus.sys_ctu_x_o !== m_x || bus.sys_ctu_y_o !== m_y) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got st=%b cnt=%0d busy=%b done=%b x=%0d y=%0d want st=%b cnt=%0d busy=%b done=%b x=%0d y=%0d",
                 $time, bus.state_o, bus.cnt_o, bus.busy_o, bus.done_o, bus.sys_ctu_x_o, bus.sys_ctu_y_o,
                 e_s, e_c, m_busy, m_done, m_x, m_y);
      end
    end
  end
  logic [2:0] ph_code [$];
  int         ph_len  [$];
  int         ph_last [$];
  logic [2:0] prev_s = 3'b000;
  int         prev_c = 0;
  int         run = 0;
  always @(negedge clk) begin
    if (bus.state_o != prev_s) begin
      if (prev_s != 3'b000) begin
        ph_code.push_back(prev_s);
        ph_len.push_back(run);
        ph_last.push_back(prev_c);
      end
      run = 1;
    end else run++;
    prev_s = bus.state_o;
    prev_c = int'(bus.cnt_o);
  end
  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic job(input logic [`PIC_X_WIDTH-1:0] x, input logic [`PIC_Y_WIDTH-1:0] y,
                     input bit sao, input bit inj, output int lat);
    int ninj = 0;
    bus.ctu_x_i = x;
    bus.ctu_y_i = y;
    bus.sao_en_i = sao;
    bus.start_i = 1'b1;
    lat = -1;
    #1;
    ph_code.delete();
    ph_len.delete();
    ph_last.delete();
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (inj && bus.state_o == 3'b011 && ninj < 3) begin
        bus.start_i = 1'b1;
        bus.ctu_x_i = 9;
        bus.ctu_y_i = 9;
        bus.sao_en_i = 1'b0;
        ninj++;
      end else bus.start_i = 1'b0;
      if (bus.done_o) begin
        lat = c;
        break;
      end
    end
    if (inj) chk("inject_count", ninj, 3);
  endtask
  task automatic chk_phases(input bit sao);
    int n = 0;
    #1;
    chk("ph_count", ph_code.size(), sao ? 6 : 5);
    for (int i = 0; i < 6; i++) begin
      if (i == 4 && !sao) continue;
      if (n < ph_code.size()) begin
        chk($sformatf("ph%0d_code", i), int'(ph_code[n]), int'(PH_CODE[i]));
        chk($sformatf("ph%0d_len", i), ph_len[n], PH_LEN[i]);
        chk($sformatf("ph%0d_last_cnt", i), ph_last[n], PH_LEN[i] - 1);
      end
      n++;
    end
  endtask
  initial begin
    int  lat, lat2;
    bit  found;
    bus.start_i = 1'b0;
    bus.sao_en_i = 1'b0;
    bus.ctu_x_i = '0;
    bus.ctu_y_i = '0;
    idle(2);
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_cnt", int'(bus.cnt_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_x", int'(bus.sys_ctu_x_o), 0);
    chk("rst_y", int'(bus.sys_ctu_y_o), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    idle(2);
    job(3, 2, 1'b1, 1'b0, lat);
    chk("lat_sao", lat, 1230);
    chk_phases(1'b1);
    idle(3);
    chk("hold_x", int'(bus.sys_ctu_x_o), 3);
    chk("hold_y", int'(bus.sys_ctu_y_o), 2);
    job(5, 7, 1'b0, 1'b0, lat);
    chk("lat_nosao", lat, 974);
    chk_phases(1'b0);
    idle(3);
    job(4, 1, 1'b1, 1'b1, lat);
    chk("lat_inject", lat, 1230);
    chk("inject_x", int'(bus.sys_ctu_x_o), 4);
    chk("inject_y", int'(bus.sys_ctu_y_o), 1);
    idle(3);
    job(6, 3, 1'b1, 1'b0, lat);
    job(2, 5, 1'b1, 1'b0, lat2);
    chk("b2b_first", lat, 1230);
    chk("b2b_gap", lat2, 1230);
    chk("b2b_x", int'(bus.sys_ctu_x_o), 2);
    idle(3);
    bus.ctu_x_i = 8;
    bus.ctu_y_i = 8;
    bus.sao_en_i = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (bus.state_o == 3'b010 && bus.cnt_o == 9'd50) found = 1'b1;
    end
    chk("reach_dbu50", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", int'(bus.state_o), 0);
    chk("midrst_cnt", int'(bus.cnt_o), 0);
    chk("midrst_busy", int'(bus.busy_o), 0);
    chk("midrst_done", int'(bus.done_o), 0);
    bus.start_i = 1'b1;
    idle(2);
    rst = 1'b0;
    bus.start_i = 1'b0;
    idle(5);
    chk("post_rst_idle", int'(bus.state_o), 0);
    job(1, 1, 1'b1, 1'b0, lat);
    chk("lat_after_rst", lat, 1230);
    idle(3);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/db_ctrl.md
DB_CTRL -- requirements
Module: db_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LEN, 65, number of LOAD cycles (cnt 0..LOAD_LEN-1).
REQ-002 SHALL have parameter DBY_LEN, 260, number of DBY cycles (256 edge cycles + 4 drain).
REQ-003 SHALL have parameter DBC_LEN, 132, number of cycles for each of DBU and DBV.
REQ-004 SHALL have parameter SAO_LEN, 256, number of SAO cycles.
REQ-005 SHALL have parameter OUT_LEN, 384, number of OUT cycles.
REQ-006 SHALL have port clk input 1, sole clock, all state on rising edge.
REQ-007 SHALL have port rst input 1, asynchronous active-high reset.
REQ-008 SHALL have port start_i input 1, single-cycle request to process one CTU.
REQ-009 SHALL have port sao_en_i input 1, sampled with start_i; 0 skips the SAO state.
REQ-010 SHALL have port ctu_x_i input `PIC_X_WIDTH, CTU column, sampled with start_i.
REQ-011 SHALL have port ctu_y_i input `PIC_Y_WIDTH, CTU row, sampled with start_i.
REQ-012 SHALL have port state_o output 3, current phase: IDLE 000, LOAD 001, DBY 011, DBU 010, DBV 110, SAO 100, OUT 101.
REQ-013 SHALL have port cnt_o output 9, cycle index within the current phase.
REQ-014 SHALL have port sys_ctu_x_o output `PIC_X_WIDTH, latched CTU column, stable for the whole job.
REQ-015 SHALL have port sys_ctu_y_o output `PIC_Y_WIDTH, latched CTU row, stable for the whole job.
REQ-016 SHALL have port busy_o output 1, high whenever state_o != IDLE.
REQ-017 SHALL have port done_o output 1, one-cycle pulse on job completion.

Function
REQ-018 SHALL use a registered FSM with state_o driven directly from the state register (no decode glitches).
REQ-019 SHALL, in IDLE with start_i=1, latch ctu_x_i, ctu_y_i, sao_en_i and enter LOAD next cycle with cnt_o=0.
REQ-020 SHALL ignore start_i while busy_o=1 (no queuing, no restart, latched values unchanged).
REQ-021 SHALL increment cnt_o by 1 every cycle in a non-IDLE state and clear it to 0 on every state change.
REQ-022 SHALL transition when cnt_o equals phase length minus 1: LOAD->DBY, DBY->DBU, DBU->DBV, DBV->SAO if latched sao_en=1 else OUT, SAO->OUT, OUT->IDLE.
REQ-023 SHALL hold cnt_o=0 in IDLE.
REQ-024 SHALL assert done_o in the first IDLE cycle after OUT's last cycle, for exactly one cycle.
REQ-025 SHALL accept a start_i asserted in that same done_o cycle (back-to-back jobs, zero idle gap beyond that one IDLE cycle).
REQ-026 SHALL never let cnt_o exceed 9 bits; every phase length parameter SHALL be 1..512, longer values unsupported.
REQ-027 SHALL give total job latency from start_i to done_o of 1+LOAD_LEN+DBY_LEN+2*DBC_LEN+(sao_en?SAO_LEN:0)+OUT_LEN cycles (1230 with SAO, 974 without, at defaults).
REQ-028 SHALL keep sys_ctu_x_o/sys_ctu_y_o unchanged in IDLE until the next accepted start_i.

Reset
REQ-029 SHALL, on rst asserted, immediately force state_o=IDLE, cnt_o=0, busy_o=0, done_o=0, sys_ctu_x_o=0, sys_ctu_y_o=0, latched sao_en=0.
REQ-030 SHALL, on rst asserted mid-job, abandon the job without done_o; first start_i after rst release begins a fresh job.
REQ-031 SHALL ignore start_i while rst is high.

Verification
REQ-032 SHALL cover: start_i with ctu=(3,2), sao_en=1 -> phases 001,011,010,110,100,101 lasting 65,260,132,132,256,384 cycles, done_o at cycle 1230, sys_ctu outputs 3/2 throughout.
REQ-033 SHALL cover: sao_en_i=0 -> DBV last cycle (cnt_o=131) followed by OUT cnt_o=0, state 100 never seen, done_o at cycle 974.
REQ-034 SHALL cover: start_i pulses during DBY with ctu=(9,9) -> ignored, job completes with original ctu values, single done_o.
REQ-035 SHALL cover: start_i in the done_o cycle -> next LOAD begins following cycle, two done_o pulses 1230 cycles apart.
REQ-036 SHALL cover: rst asserted at DBU cnt_o=50 -> same-cycle state_o=000, cnt_o=0, busy_o=0, no done_o; subsequent start_i runs a full job.
REQ-037 SHALL cover: boundary check that cnt_o at each phase's last cycle equals length-1 (64, 259, 131, 131, 255, 383) and wraps to 0 on transition.
